gh_uart_rx_deser: RTL and testbench

UART receive deserializer that recovers bytes from the serial line using a 16x baud-rate enable. Each assembled word is presented with a one-cycle `load` strobe that drives the clock-enable of the downstream receive holding register. The block sits between the serial input pin and the RX holding register / RX FIFO write port in the UART core.

---
 rtl/gh_uart_rx_deser.sv | 192 +++++++++++++++++++
 tb/tb_gh_uart_rx_deser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gh_uart_rx_deser.sv
// rtl/gh_uart_rx_deser.sv - UART RX deserializer, 16x oversampled, optional parity via UART_RX_PARITY_EN
module gh_uart_rx_deser #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            brc16,
  input  logic            sdin,
  input  logic            parity_odd,
  output logic [size-1:0] D,
  output logic            load,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [size-1:0]   shift_q, shift_d;
  logic [size-1:0]   d_q, d_d;
  logic              load_q, load_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              sync1_q, sdin_s_q;

`ifdef UART_RX_PARITY_EN
  logic              par_bit_q, par_bit_d;
  logic              parity_err_q, parity_err_d;
`else
  logic              unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Two-flop synchronizer for the asynchronous serial line; idles high out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sdin_s_q <= 1'b1;
    end else begin
      sync1_q  <= sdin;
      sdin_s_q <= sync1_q;
    end
  end

  // Frame sequencing: all state moves happen only on brc16 ticks
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    d_d         = d_q;
    load_d      = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif
    if (brc16) begin
      case (state_q)
        S_IDLE: begin
          if (!sdin_s_q) begin
            cnt_d   = 4'd0;
            state_d = S_START;
          end
        end
        S_START: begin
          // Re-check the line at mid start bit to reject short glitches
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (!sdin_s_q) begin
              idx_d   = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 4'd15) begin
            shift_d = {sdin_s_q, shift_q[size-1:1]};
            cnt_d   = 4'd0;
            if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == 4'd15) begin
            par_bit_d = sdin_s_q;
            cnt_d     = 4'd0;
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
`endif
        S_STOP: begin
          // Publish at mid-stop so a following start edge half a bit later is caught
          if (cnt_q == 4'd15) begin
            d_d         = shift_q;
            frame_err_d = ~sdin_s_q;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^shift_q) ^ par_bit_q ^ parity_odd;
`endif
            load_d      = 1'b1;
            cnt_d       = 4'd0;
            state_d     = sdin_s_q ? S_IDLE : S_WAIT_HI;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_WAIT_HI: begin
          // Break or framing error: hold off until the line recovers high
          if (sdin_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      shift_q     <= '0;
      d_q         <= '0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      d_q         <= d_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity capture and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign D         = d_q;
  assign load      = load_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gh_uart_rx_deser.sv
// tb/tb_gh_uart_rx_deser.sv - directed bench for gh_uart_rx_deser
module tb_gh_uart_rx_deser;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = 176;
`else
  localparam int FRAME_TICKS = 160;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       brc16 = 1'b0;
  logic       sdin = 1'b1;
  logic       parity_odd = 1'b1;
  logic [7:0] D;
  logic       load, frame_err, parity_err, busy;

  int errors = 0;
  int checks = 0;

  int         tick_n = 0;
  int         nloads = 0;
  int         load_cycles = 0;
  int         ld_tick [8];
  logic [7:0] ld_d [8];
  logic       ld_fe [8];
  logic       ld_pe [8];

  gh_uart_rx_deser #(.size(8)) dut (
    .clk(clk), .rst(rst), .brc16(brc16), .sdin(sdin), .parity_odd(parity_odd),
    .D(D), .load(load), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      brc16 = 1'b1;
      @(negedge clk);
      brc16 = 1'b0;
    end
  end

  always @(posedge clk) if (brc16) tick_n++;

  always @(negedge clk) begin
    if (load) begin
      load_cycles++;
      if (nloads < 8) begin
        ld_tick[nloads] = tick_n;
        ld_d[nloads]    = D;
        ld_fe[nloads]   = frame_err;
        ld_pe[nloads]   = parity_err;
      end
      nloads++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sdin = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // start, 8 data LSB first, optional parity, then stop (high, or low for stop_low bit times)
  task automatic send_frame(input logic [7:0] data, input int stop_low, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ parity_odd ^ bad_par);
`else
    if (bad_par) sdin = 1'b1;
`endif
    if (stop_low == 0) send_bit(1'b1);
    else for (int i = 0; i < stop_low; i++) send_bit(1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_D", D, 8'h00);
    check("rst_load", load, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (2) send_bit(1'b1);

    // glitch of 4 ticks: START must abort without a load
    sdin = 1'b0;
    repeat (16) @(negedge clk);
    check("glitch_busy_up", busy, 1'b1);
    sdin = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch_nloads", nloads, 0);
    check("glitch_D", D, 8'h00);
    check("glitch_busy_down", busy, 1'b0);

    // clean 0x55
    send_frame(8'h55, 0, 1'b0);
    send_bit(1'b1);
    check("f55_nloads", nloads, 1);
    check("f55_D", ld_d[0], 8'h55);
    check("f55_fe", ld_fe[0], 1'b0);
    check("f55_pe", ld_pe[0], 1'b0);
    check("f55_busy", busy, 1'b0);
    check("f55_hold_D", D, 8'h55);

    // 0xA3 with stop held low 3 bit times, then 0x3C
    send_frame(8'hA3, 3, 1'b0);
    check("fa3_nloads", nloads, 2);
    check("fa3_D", ld_d[1], 8'hA3);
    check("fa3_fe", ld_fe[1], 1'b1);
    check("fa3_wait_busy", busy, 1'b1);
    send_bit(1'b1);
    check("fa3_recover_busy", busy, 1'b0);
    check("fa3_hold_fe", frame_err, 1'b1);
    send_frame(8'h3C, 0, 1'b0);
    send_bit(1'b1);
    check("f3c_nloads", nloads, 3);
    check("f3c_D", ld_d[2], 8'h3C);
    check("f3c_fe", ld_fe[2], 1'b0);

    // back-to-back 0xA5, 0x3C
    send_frame(8'hA5, 0, 1'b0);
    send_frame(8'h3C, 0, 1'b0);
    send_bit(1'b1);
    check("b2b_nloads", nloads, 5);
    check("b2b_D0", ld_d[3], 8'hA5);
    check("b2b_D1", ld_d[4], 8'h3C);
    check("b2b_spacing", ld_tick[4] - ld_tick[3], FRAME_TICKS);
    check("b2b_fe1", ld_fe[4], 1'b0);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b1;
    send_frame(8'h07, 0, 1'b0);
    send_bit(1'b1);
    check("par_ok_pe", parity_err, 1'b0);
    check("par_ok_D", D, 8'h07);
    send_frame(8'h07, 0, 1'b1);
    send_bit(1'b1);
    check("par_bad_pe", parity_err, 1'b1);
    check("par_bad_nloads", nloads, 7);
    nloads = 5;
`endif

    // reset during data bit 4
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    sdin = 1'b0;
    repeat (32) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_D", D, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_load", load, 1'b0);
    check("mid_rst_fe", frame_err, 1'b0);
    sdin = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    send_bit(1'b1);
    check("post_rst_nloads", nloads, 5);
    send_frame(8'h81, 0, 1'b0);
    send_bit(1'b1);
    check("f81_nloads", nloads, 6);
    check("f81_D", ld_d[5], 8'h81);
    check("f81_out_D", D, 8'h81);
`ifdef UART_RX_PARITY_EN
    check("load_one_cycle", load_cycles, 8);
`else
    check("load_one_cycle", load_cycles, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
